// File: rtl/usb_pkg.sv
// usb_pkg: shared definitions for the USB read/write sequencer.
//   - PID constants in wire bit order (OUT, IN, DATA0)
//   - seq_state_t : sequencer FSM states
//   - op_t        : operation latched at request accept
//   - rev7/rev4   : bit reversal for the token address and endpoint fields
package usb_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 16;
  localparam int TOK_W  = 19;
  localparam int PKT_W  = 72;

  localparam logic [7:0] PID_OUT   = 8'h87;
  localparam logic [7:0] PID_IN    = 8'h96;
  localparam logic [7:0] PID_DATA0 = 8'hC3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_TOK,
    ADDR_WAIT,
    DATA_TOK,
    DATA_WAIT,
    FINISH
  } seq_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

  function automatic logic [6:0] rev7(input logic [6:0] v);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = v[6-i];
    return r;
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[3-i];
    return r;
  endfunction

endpackage

// File: rtl/usb_rw_sequencer_if.sv
// usb_rw_sequencer_if: bundles the host request side and the protocol
// engine side of the sequencer.
//   master : the sequencer (drives token/data_pkt/token_avail and host results,
//            receives requests and engine status)
//   slave  : the environment (host + protocol engine)
// Host side  : req_read, req_write, mem_addr, wr_data -> busy, done, success, rd_data
// Engine side: proto_ready_in, proto_done, proto_success, proto_data -> token, data_pkt, token_avail
interface usb_rw_sequencer_if;
  import usb_pkg::*;

  logic                req_read;
  logic                req_write;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                proto_ready_in;
  logic                proto_done;
  logic                proto_success;
  logic [DATA_W-1:0]   proto_data;
  logic [TOK_W-1:0]    token;
  logic [PKT_W-1:0]    data_pkt;
  logic                token_avail;
  logic                busy;
  logic                done;
  logic                success;
  logic [DATA_W-1:0]   rd_data;

  modport master (
    input  req_read, req_write, mem_addr, wr_data,
    input  proto_ready_in, proto_done, proto_success, proto_data,
    output token, data_pkt, token_avail,
    output busy, done, success, rd_data
  );

  modport slave (
    output req_read, req_write, mem_addr, wr_data,
    output proto_ready_in, proto_done, proto_success, proto_data,
    input  token, data_pkt, token_avail,
    input  busy, done, success, rd_data
  );

endinterface

// File: rtl/seq_watchdog.sv
// seq_watchdog: cycle counter that flags a stalled protocol transaction.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the count from zero (takes priority over en)
//   en       : count while high
//   expired  : high while en and the count has reached WDOG_CYCLES-1
module seq_watchdog #(
  parameter int WDOG_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expired = en && (cnt == LAST);

  // Holds at LAST so the count can never wrap if the owner lingers.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/usb_rw_sequencer.sv
// usb_rw_sequencer: runs one 8-byte memory read or write on the USB device
// as two protocol-engine transactions: an OUT carrying the memory address to
// ADDR_EP, then an IN (read) or OUT (write) on DATA_EP.
//   clk, rst : clock, synchronous active-high reset (engine shares rst)
//   bus      : usb_rw_sequencer_if.master (host requests/results, engine
//              token/data_pkt/token_avail and done/success/data status)
// A watchdog aborts a phase with success=0 if the engine never reports done.
module usb_rw_sequencer
  import usb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'd5,
  parameter logic [3:0] ADDR_EP     = 4'd4,
  parameter logic [3:0] DATA_EP     = 4'd8,
  parameter int         WDOG_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  usb_rw_sequencer_if.master bus
);

  localparam logic [TOK_W-1:0] TOK_ADDR = {PID_OUT, rev7(DEV_ADDR), rev4(ADDR_EP)};
  localparam logic [TOK_W-1:0] TOK_RD   = {PID_IN,  rev7(DEV_ADDR), rev4(DATA_EP)};
  localparam logic [TOK_W-1:0] TOK_WR   = {PID_OUT, rev7(DEV_ADDR), rev4(DATA_EP)};

  seq_state_t        state;
  op_t               op;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              tok_state;
  logic              wd_en;
  logic              wd_expired;

  assign accept    = (state == IDLE) && (bus.req_read || bus.req_write);
  assign tok_state = (state == ADDR_TOK) || (state == DATA_TOK);
  assign wd_en     = (state == ADDR_WAIT) || (state == DATA_WAIT);

  // The strobe follows readyIn within the same cycle so a request seen with
  // the engine idle produces its token one cycle later; leaving the TOK state
  // on that same edge guarantees a single strobe per phase.
  assign bus.token_avail = tok_state && bus.proto_ready_in;

  seq_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.token_avail),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Write payload is pure data: captured at accept, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) wdata_q <= bus.wr_data;
  end

  // Sequencer FSM with registered host/engine outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op           <= OP_READ;
      bus.token    <= '0;
      bus.data_pkt <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.success  <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            // Read wins a collision; the write is dropped.
            op           <= bus.req_read ? OP_READ : OP_WRITE;
            bus.token    <= TOK_ADDR;
            bus.data_pkt <= {PID_DATA0, bus.mem_addr, 48'd0};
            bus.busy     <= 1'b1;
            state        <= ADDR_TOK;
          end
        end
        ADDR_TOK: begin
          if (bus.proto_ready_in) state <= ADDR_WAIT;
        end
        ADDR_WAIT: begin
          // token/data_pkt stay put: the engine resamples them on retries.
          if (bus.proto_done) begin
            if (bus.proto_success) begin
              bus.token <= (op == OP_READ) ? TOK_RD : TOK_WR;
              if (op == OP_WRITE) bus.data_pkt <= {PID_DATA0, wdata_q};
              state <= DATA_TOK;
            end else begin
              bus.done    <= 1'b1;
              bus.success <= 1'b0;
              state       <= FINISH;
            end
          end else if (wd_expired) begin
            bus.done    <= 1'b1;
            bus.success <= 1'b0;
            state       <= FINISH;
          end
        end
        DATA_TOK: begin
          if (bus.proto_ready_in) state <= DATA_WAIT;
        end
        DATA_WAIT: begin
          if (bus.proto_done) begin
            bus.done    <= 1'b1;
            bus.success <= bus.proto_success;
            if (op == OP_READ && bus.proto_success) bus.rd_data <= bus.proto_data;
            state <= FINISH;
          end else if (wd_expired) begin
            bus.done    <= 1'b1;
            bus.success <= 1'b0;
            state       <= FINISH;
          end
        end
        FINISH: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rw_sequencer.sv
// tb_usb_rw_sequencer: directed bench for usb_rw_sequencer. The bench acts as
// host and protocol engine; inputs change and outputs are sampled on the
// falling clock edge.
module tb_usb_rw_sequencer;

  localparam logic [18:0] T_ADDR = {8'h87, 7'b1010000, 4'b0010};
  localparam logic [18:0] T_RD   = {8'h96, 7'b1010000, 4'b0001};
  localparam logic [18:0] T_WR   = {8'h87, 7'b1010000, 4'b0001};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  usb_rw_sequencer_if bus ();

  usb_rw_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // Drive a request, let the address phase succeed at once; returns at the
  // falling edge of the DATA_TOK cycle with proto_ready_in high.
  task automatic start_and_pass_addr(input logic rd, input logic [15:0] a, input logic [63:0] w);
    step();
    bus.req_read = rd; bus.req_write = !rd; bus.mem_addr = a; bus.wr_data = w;
    bus.proto_ready_in = 1'b1;
    step();
    bus.req_read = 1'b0; bus.req_write = 1'b0;
    step();
    bus.proto_done = 1'b1; bus.proto_success = 1'b1;
    step();
    bus.proto_done = 1'b0; bus.proto_success = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    rst = 1'b0;
    n_cmp++;
    if ({bus.token, bus.data_pkt, bus.token_avail, bus.busy, bus.done, bus.success, bus.rd_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got tok=%h pkt=%h avail=%b busy=%b done=%b succ=%b rd=%h expected all zero",
               bus.token, bus.data_pkt, bus.token_avail, bus.busy, bus.done, bus.success, bus.rd_data);
    end
  endtask

  task automatic test_read();
    int strobes;
    logic moved;
    step();
    bus.req_read = 1'b1; bus.mem_addr = 16'h1234; bus.proto_ready_in = 1'b1;
    step();
    bus.req_read = 1'b0; bus.mem_addr = 16'h0000;
    n_cmp++;
    if (bus.token_avail !== 1'b1) begin n_bad++; $display("FAIL read_addr_strobe: got %b expected 1", bus.token_avail); end
    n_cmp++;
    if (bus.token !== T_ADDR) begin n_bad++; $display("FAIL read_addr_token: got %h expected %h", bus.token, T_ADDR); end
    n_cmp++;
    if (bus.data_pkt !== 72'hC3_1234_000000000000) begin n_bad++; $display("FAIL read_addr_pkt: got %h expected c31234000000000000", bus.data_pkt); end
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL read_busy: got %b expected 1", bus.busy); end
    strobes = 0; moved = 1'b0;
    repeat (10) begin
      step();
      if (bus.token_avail) strobes++;
      if (bus.data_pkt !== 72'hC3_1234_000000000000 || bus.token !== T_ADDR) moved = 1'b1;
    end
    n_cmp++;
    if (moved !== 1'b0) begin n_bad++; $display("FAIL read_addr_hold: got moved=%b expected 0", moved); end
    bus.proto_done = 1'b1; bus.proto_success = 1'b1;
    step();
    bus.proto_done = 1'b0; bus.proto_success = 1'b0;
    n_cmp++;
    if (strobes !== 0) begin n_bad++; $display("FAIL read_addr_restrobe: got %0d expected 0", strobes); end
    n_cmp++;
    if (bus.token_avail !== 1'b1 || bus.token !== T_RD) begin
      n_bad++; $display("FAIL read_data_token: got avail=%b tok=%h expected avail=1 tok=%h", bus.token_avail, bus.token, T_RD);
    end
    repeat (10) step();
    bus.proto_done = 1'b1; bus.proto_success = 1'b1; bus.proto_data = 64'hDEADBEEF_CAFEF00D;
    step();
    bus.proto_done = 1'b0; bus.proto_success = 1'b0; bus.proto_data = '0;
    n_cmp++;
    if (bus.done !== 1'b1 || bus.success !== 1'b1 || bus.rd_data !== 64'hDEADBEEF_CAFEF00D) begin
      n_bad++; $display("FAIL read_finish: got done=%b succ=%b rd=%h expected 1 1 deadbeefcafef00d", bus.done, bus.success, bus.rd_data);
    end
    step();
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL read_idle: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_write();
    logic moved;
    step();
    bus.req_write = 1'b1; bus.mem_addr = 16'h00A5; bus.wr_data = 64'h0123456789ABCDEF;
    step();
    bus.req_write = 1'b0; bus.wr_data = 64'hFFFF_0000_FFFF_0000;
    step();
    bus.proto_done = 1'b1; bus.proto_success = 1'b1;
    step();
    bus.proto_done = 1'b0; bus.proto_success = 1'b0;
    n_cmp++;
    if (bus.token !== T_WR || bus.data_pkt !== 72'hC3_0123456789ABCDEF || bus.token_avail !== 1'b1) begin
      n_bad++; $display("FAIL write_data_tok: got tok=%h pkt=%h avail=%b expected %h c30123456789abcdef 1", bus.token, bus.data_pkt, bus.token_avail, T_WR);
    end
    moved = 1'b0;
    repeat (10) begin
      step();
      if (bus.data_pkt !== 72'hC3_0123456789ABCDEF) moved = 1'b1;
    end
    n_cmp++;
    if (moved !== 1'b0) begin n_bad++; $display("FAIL write_pkt_hold: got moved=%b expected 0", moved); end
    bus.proto_done = 1'b1; bus.proto_success = 1'b1; bus.proto_data = 64'h1111_2222_3333_4444;
    step();
    bus.proto_done = 1'b0; bus.proto_success = 1'b0; bus.proto_data = '0;
    n_cmp++;
    if (bus.done !== 1'b1 || bus.success !== 1'b1 || bus.rd_data !== 64'hDEADBEEF_CAFEF00D) begin
      n_bad++; $display("FAIL write_finish: got done=%b succ=%b rd=%h expected 1 1 deadbeefcafef00d", bus.done, bus.success, bus.rd_data);
    end
    step();
  endtask

  task automatic test_addr_fail();
    int strobes;
    step();
    bus.req_read = 1'b1; bus.mem_addr = 16'h0042;
    step();
    bus.req_read = 1'b0;
    repeat (3) step();
    bus.proto_done = 1'b1; bus.proto_success = 1'b0;
    step();
    bus.proto_done = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b1 || bus.success !== 1'b0 || bus.token_avail !== 1'b0) begin
      n_bad++; $display("FAIL addrfail_finish: got done=%b succ=%b avail=%b expected 1 0 0", bus.done, bus.success, bus.token_avail);
    end
    strobes = 0;
    repeat (4) begin
      step();
      if (bus.token_avail || bus.done || bus.busy) strobes++;
    end
    n_cmp++;
    if (strobes !== 0) begin n_bad++; $display("FAIL addrfail_quiet: got %0d active cycles expected 0", strobes); end
  endtask

  task automatic test_watchdog();
    int cyc;
    logic early;
    start_and_pass_addr(1'b1, 16'h0777, 64'h0);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 5000) begin
      step();
      cyc++;
    end
    n_cmp++;
    if (cyc !== 4097) begin n_bad++; $display("FAIL wdog_latency: got %0d cycles expected 4097", cyc); end
    n_cmp++;
    if (bus.success !== 1'b0 || bus.rd_data !== 64'hDEADBEEF_CAFEF00D) begin
      n_bad++; $display("FAIL wdog_result: got succ=%b rd=%h expected 0 deadbeefcafef00d", bus.success, bus.rd_data);
    end
    step();
    // Stray engine done while idle must be ignored.
    bus.proto_done = 1'b1; bus.proto_success = 1'b1; bus.proto_data = 64'h5555;
    step();
    bus.proto_done = 1'b0; bus.proto_success = 1'b0; bus.proto_data = '0;
    step();
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.rd_data !== 64'hDEADBEEF_CAFEF00D) begin
      n_bad++; $display("FAIL stray_done: got done=%b busy=%b rd=%h expected 0 0 deadbeefcafef00d", bus.done, bus.busy, bus.rd_data);
    end
    // proto_done on the expiry cycle takes precedence over the watchdog.
    start_and_pass_addr(1'b1, 16'h0888, 64'h0);
    early = 1'b0;
    repeat (4096) begin
      step();
      if (bus.done) early = 1'b1;
    end
    bus.proto_done = 1'b1; bus.proto_success = 1'b1; bus.proto_data = 64'h0BAD_F00D_1234_5678;
    step();
    bus.proto_done = 1'b0; bus.proto_success = 1'b0; bus.proto_data = '0;
    n_cmp++;
    if (early !== 1'b0 || bus.done !== 1'b1 || bus.success !== 1'b1 || bus.rd_data !== 64'h0BAD_F00D_1234_5678) begin
      n_bad++; $display("FAIL wdog_tie: got early=%b done=%b succ=%b rd=%h expected 0 1 1 0badf00d12345678", early, bus.done, bus.success, bus.rd_data);
    end
    step();
  endtask

  task automatic test_ready_collision();
    int strobes;
    bus.proto_ready_in = 1'b0;
    step();
    bus.req_read = 1'b1; bus.req_write = 1'b1; bus.mem_addr = 16'hBEEF; bus.wr_data = 64'h7777;
    step();
    bus.req_read = 1'b0;
    strobes = 0;
    repeat (5) begin
      if (bus.token_avail) strobes++;
      step();
    end
    n_cmp++;
    if (strobes !== 0) begin n_bad++; $display("FAIL notready_strobe: got %0d expected 0", strobes); end
    bus.proto_ready_in = 1'b1;
    #1;
    n_cmp++;
    if (bus.token_avail !== 1'b1 || bus.token !== T_ADDR || bus.data_pkt !== 72'hC3_BEEF_000000000000) begin
      n_bad++; $display("FAIL ready_strobe: got avail=%b tok=%h pkt=%h expected 1 %h c3beef000000000000", bus.token_avail, bus.token, bus.data_pkt, T_ADDR);
    end
    step();
    n_cmp++;
    if (bus.token_avail !== 1'b0) begin n_bad++; $display("FAIL ready_single: got %b expected 0", bus.token_avail); end
    bus.proto_done = 1'b1; bus.proto_success = 1'b1;
    step();
    bus.proto_done = 1'b0; bus.proto_success = 1'b0; bus.req_write = 1'b0;
    n_cmp++;
    if (bus.token !== T_RD) begin n_bad++; $display("FAIL collision_read: got %h expected %h", bus.token, T_RD); end
    step();
    bus.proto_done = 1'b1; bus.proto_success = 1'b1; bus.proto_data = 64'hA5A5_A5A5_5A5A_5A5A;
    step();
    bus.proto_done = 1'b0; bus.proto_success = 1'b0; bus.proto_data = '0;
    n_cmp++;
    if (bus.done !== 1'b1 || bus.success !== 1'b1 || bus.rd_data !== 64'hA5A5_A5A5_5A5A_5A5A) begin
      n_bad++; $display("FAIL collision_finish: got done=%b succ=%b rd=%h expected 1 1 a5a5a5a55a5a5a5a", bus.done, bus.success, bus.rd_data);
    end
    step();
    step();
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL busy_write_ignored: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int active;
    start_and_pass_addr(1'b0, 16'h0101, 64'h9999);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({bus.token, bus.data_pkt, bus.token_avail, bus.busy, bus.done, bus.success, bus.rd_data} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got tok=%h pkt=%h avail=%b busy=%b done=%b succ=%b rd=%h expected all zero",
               bus.token, bus.data_pkt, bus.token_avail, bus.busy, bus.done, bus.success, bus.rd_data);
    end
    active = 0;
    repeat (3) begin
      step();
      if (bus.done || bus.busy) active++;
    end
    n_cmp++;
    if (active !== 0) begin n_bad++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", active); end
    bus.req_read = 1'b1; bus.mem_addr = 16'h0202;
    step();
    bus.req_read = 1'b0;
    n_cmp++;
    if (bus.token_avail !== 1'b1 || bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL midreset_restart: got avail=%b busy=%b expected 1 1", bus.token_avail, bus.busy);
    end
  endtask

  initial begin
    bus.req_read = 1'b0; bus.req_write = 1'b0; bus.mem_addr = '0; bus.wr_data = '0;
    bus.proto_ready_in = 1'b0; bus.proto_done = 1'b0; bus.proto_success = 1'b0; bus.proto_data = '0;
    test_reset();
    test_read();
    test_write();
    test_addr_fail();
    test_watchdog();
    test_ready_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/usb_rw_sequencer.md
Name: usb_rw_sequencer

Overview:
- Transaction-level host controller that sequences the packet-level protocol engine for one 8-byte memory read or write on the USB device.
- Each request runs two protocol transactions. First, an OUT transaction to the address endpoint carries the memory address. Second, an IN transaction (read) or OUT transaction (write) runs on the data endpoint.
- Sits between the host-side request interface and the protocol engine's tokenRW/dataRW/pktInAvailRW/done/success/readyIn/dataOut ports.
- Adds a watchdog and first-phase abort on top of the engine's own retry handling.

Parameters:
DEV_ADDR, 7'd5, USB device address placed in every token
ADDR_EP, 4'd4, endpoint receiving the memory address
DATA_EP, 4'd8, endpoint carrying read/write payload
WDOG_CYCLES, 4096, max cycles waiting for proto_done before abort

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
req_read  in  1  start read (sampled in IDLE only)
req_write  in  1  start write (sampled in IDLE only)
mem_addr  in  16  memory address, captured at accept
wr_data  in  64  write payload, captured at accept
proto_ready_in  in  1  protocol engine idle (readyIn)
proto_done  in  1  protocol transaction finished, 1-cycle pulse
proto_success  in  1  protocol transaction succeeded, valid with proto_done
proto_data  in  64  IN payload (dataOut), valid with proto_done
token  out  19  {pid[7:0], addr[6:0], endp[3:0]} to tokenRW
data_pkt  out  72  {pid[7:0], payload[63:0]} to dataRW
token_avail  out  1  1-cycle token strobe to pktInAvailRW
busy  out  1  request in progress
done  out  1  1-cycle completion pulse
success  out  1  result, valid with done
rd_data  out  64  last successful read payload

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high.
- Reset: state=IDLE. token, data_pkt, token_avail, busy, done, success and rd_data are all 0. Watchdog is cleared.
- Reset mid-transaction: abandons the request with no done pulse. The engine is reset from the same rst.
- PID constants (wire bit order): OUT=8'h87, IN=8'h96, DATA0=8'hC3.
- Token addr/endp fields are bit-reversed copies of DEV_ADDR and the endpoint.
- States:
  - IDLE: busy=0. req_read and req_write both high → read wins and the write is dropped. Accepting a request latches op, mem_addr and wr_data, then goes to ADDR_TOK. Requests while busy are ignored.
  - ADDR_TOK: token={OUT, rev(DEV_ADDR), rev(ADDR_EP)}; data_pkt={DATA0, mem_addr, 48'd0}. When proto_ready_in=1, token_avail=1 for exactly that cycle, then go to ADDR_WAIT.
  - ADDR_WAIT: token and data_pkt held stable, since the engine resamples data_pkt on every retry.
    - proto_done & proto_success → DATA_TOK.
    - proto_done & !proto_success → FINISH with success=0; the data phase is skipped.
  - DATA_TOK: read uses token={IN, rev(DEV_ADDR), rev(DATA_EP)}. Write uses the OUT PID and data_pkt={DATA0, wr_data}. Strobe rule is the same as ADDR_TOK; then go to DATA_WAIT.
  - DATA_WAIT: data_pkt held stable.
    - proto_done → FINISH with success=proto_success.
    - On a read with proto_success=1, rd_data<=proto_data in the same cycle.
  - FINISH: done=1 for one cycle, success valid, then IDLE. busy is high from ADDR_TOK through FINISH.
- Latency: request at cycle N with proto_ready_in=1 → token_avail at N+1. done is asserted 1 cycle after the final proto_done.
- Watchdog: counter cleared on entry to ADDR_WAIT/DATA_WAIT and counts while in them. Reaching WDOG_CYCLES-1 without proto_done → FINISH with success=0.
- Simultaneous proto_done and watchdog expiry: proto_done wins.
- proto_done outside the WAIT states is ignored.
- rd_data is unchanged on writes and failed reads. success holds its value until the next done.
- token_avail is never asserted twice per phase.

Decomposition:
- Shared package usb_pkg holds:
  - PID constants (PID_OUT, PID_IN, PID_DATA0)
  - seq_state_t enum {IDLE, ADDR_TOK, ADDR_WAIT, DATA_TOK, DATA_WAIT, FINISH}
  - op_t {OP_READ, OP_WRITE}
  - functions rev7/rev4 for bit reversal
- One sub-module, seq_watchdog, with ports clk, rst, clr, en, expired; WDOG_CYCLES is its parameter.

Test Plan:
1. Read, both phases succeed:
   - Stimulus: req_read, mem_addr=16'h1234; engine returns done+success after 10 cycles per phase, with proto_data=64'hDEADBEEF_CAFEF00D.
   - Response: first token={8'h87, rev(5), rev(4)} with data_pkt[63:48]=16'h1234; second token uses PID 8'h96 and endp rev(8). done=1, success=1, rd_data=64'hDEADBEEF_CAFEF00D.
2. Write:
   - Stimulus: req_write, wr_data=64'h0123456789ABCDEF.
   - Response: data_pkt=72'hC3_0123456789ABCDEF, stable for all of DATA_WAIT; done=1, success=1; rd_data unchanged.
3. Address phase fails:
   - Stimulus: proto_done with proto_success=0 in ADDR_WAIT.
   - Response: no second token_avail; done=1 and success=0 one cycle later.
4. Watchdog:
   - Stimulus: no proto_done for 4096 cycles in DATA_WAIT.
   - Response: done=1, success=0, rd_data unchanged; next request accepted normally.
5. Engine not ready, and request collision:
   - Stimulus: proto_ready_in=0 for 5 cycles in ADDR_TOK → token_avail only on the first cycle ready=1.
   - Stimulus: req_read=req_write=1 in IDLE → read sequence runs.
   - Stimulus: req_write while busy → ignored.
6. Reset:
   - Stimulus: rst for 1 cycle during DATA_WAIT.
   - Response: all outputs 0 at the next cycle, no done pulse, IDLE.
